// File: rtl/req_busy_gnt_monitor.sv
// Per-channel req -> busy[*MIN:MAX] -> gnt protocol monitor with pass/fail pulses, cause codes and saturating totals.
// Verdicts are registered at the deciding edge; the monitor only observes and never stalls the channels.
module req_busy_gnt_monitor #(
  parameter int NUM_CH   = 4,
  parameter int MIN_BUSY = 1,
  parameter int MAX_BUSY = 5,
  parameter int CNT_W    = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  chk_en_i,
  input  logic                  cnt_clr_i,
  input  logic [NUM_CH-1:0]     req_i,
  input  logic [NUM_CH-1:0]     busy_i,
  input  logic [NUM_CH-1:0]     gnt_i,
  output logic [NUM_CH-1:0]     pass_o,
  output logic [NUM_CH-1:0]     fail_o,
  output logic [3*NUM_CH-1:0]   err_code_o,
  output logic [NUM_CH-1:0]     active_o,
  output logic [CNT_W-1:0]      pass_cnt_o,
  output logic [CNT_W-1:0]      fail_cnt_o
);

  localparam int BW   = $clog2(MAX_BUSY + 1);
  localparam int SW   = $clog2(NUM_CH + 1);
  localparam int SUMW = ((CNT_W > SW) ? CNT_W : SW) + 1;

  localparam logic [BW-1:0] MIN_B = BW'(MIN_BUSY);
  localparam logic [BW-1:0] MAX_B = BW'(MAX_BUSY);

  localparam logic [2:0] ERR_NO_BUSY   = 3'd1;
  localparam logic [2:0] ERR_TOO_SHORT = 3'd2;
  localparam logic [2:0] ERR_TOO_LONG  = 3'd3;
  localparam logic [2:0] ERR_NO_GNT    = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FIRST = 2'd1,
    S_BUSY  = 2'd2
  } state_e;

  state_e              state_q [NUM_CH];
  state_e              state_d [NUM_CH];
  logic [BW-1:0]       bcnt_q  [NUM_CH];
  logic [BW-1:0]       bcnt_d  [NUM_CH];
  logic [NUM_CH-1:0]   pass_q, pass_d;
  logic [NUM_CH-1:0]   fail_q, fail_d;
  logic [3*NUM_CH-1:0] err_q, err_d;
  logic [CNT_W-1:0]    pcnt_q, pcnt_d;
  logic [CNT_W-1:0]    fcnt_q, fcnt_d;

  function automatic logic [SW-1:0] popcnt(input logic [NUM_CH-1:0] v);
    logic [SW-1:0] n;
    n = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      n = n + SW'(v[i]);
    end
    return n;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [SW-1:0] n);
    logic [SUMW-1:0] s;
    s = SUMW'(a) + SUMW'(n);
    if (s > SUMW'({CNT_W{1'b1}})) begin
      return {CNT_W{1'b1}};
    end
    return s[CNT_W-1:0];
  endfunction

  always_comb begin
    pass_d = '0;
    fail_d = '0;
    err_d  = err_q;
    for (int c = 0; c < NUM_CH; c++) begin
      state_d[c] = state_q[c];
      bcnt_d[c]  = bcnt_q[c];
      unique case (state_q[c])
        S_IDLE: begin
          if (req_i[c] && chk_en_i) begin
            state_d[c] = S_FIRST;
          end
        end
        S_FIRST: begin
          if (busy_i[c]) begin
            state_d[c] = S_BUSY;
            bcnt_d[c]  = BW'(1);
          end else begin
            state_d[c]       = S_IDLE;
            fail_d[c]        = 1'b1;
            err_d[3*c +: 3]  = ERR_NO_BUSY;
          end
        end
        S_BUSY: begin
          // Grant wins over everything once the minimum busy run is met.
          if (gnt_i[c] && (bcnt_q[c] >= MIN_B)) begin
            state_d[c] = S_IDLE;
            bcnt_d[c]  = '0;
            pass_d[c]  = 1'b1;
          end else if (busy_i[c] && (bcnt_q[c] == MAX_B)) begin
            state_d[c]      = S_IDLE;
            bcnt_d[c]       = '0;
            fail_d[c]       = 1'b1;
            err_d[3*c +: 3] = ERR_TOO_LONG;
          end else if (busy_i[c]) begin
            bcnt_d[c] = bcnt_q[c] + BW'(1);
          end else begin
            state_d[c]      = S_IDLE;
            bcnt_d[c]       = '0;
            fail_d[c]       = 1'b1;
            err_d[3*c +: 3] = (bcnt_q[c] < MIN_B) ? ERR_TOO_SHORT : ERR_NO_GNT;
          end
        end
        default: begin
          state_d[c] = S_IDLE;
          bcnt_d[c]  = '0;
        end
      endcase
    end
  end

  always_comb begin
    pcnt_d = pcnt_q;
    fcnt_d = fcnt_q;
    if (cnt_clr_i) begin
      pcnt_d = '0;
      fcnt_d = '0;
    end else begin
      pcnt_d = sat_add(pcnt_q, popcnt(pass_d));
      fcnt_d = sat_add(fcnt_q, popcnt(fail_d));
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int c = 0; c < NUM_CH; c++) begin
        state_q[c] <= S_IDLE;
        bcnt_q[c]  <= '0;
      end
      pass_q <= '0;
      fail_q <= '0;
      err_q  <= '0;
      pcnt_q <= '0;
      fcnt_q <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        state_q[c] <= state_d[c];
        bcnt_q[c]  <= bcnt_d[c];
      end
      pass_q <= pass_d;
      fail_q <= fail_d;
      err_q  <= err_d;
      pcnt_q <= pcnt_d;
      fcnt_q <= fcnt_d;
    end
  end

  always_comb begin
    active_o = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      active_o[c] = (state_q[c] != S_IDLE);
    end
  end

  assign pass_o     = pass_q;
  assign fail_o     = fail_q;
  assign err_code_o = err_q;
  assign pass_cnt_o = pcnt_q;
  assign fail_cnt_o = fcnt_q;

endmodule

// File: tb/tb_req_busy_gnt_monitor.sv
// Bench for req_busy_gnt_monitor: directed scenarios with literal expectations, then random traffic
// compared every cycle against a transaction-level model of the handshake rules.
module tb_req_busy_gnt_monitor;

  localparam int NCH  = 4;
  localparam int MINB = 2;
  localparam int MAXB = 5;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             chk_en = 1'b1;
  logic             cnt_clr = 1'b0;
  logic [NCH-1:0]   req = '0;
  logic [NCH-1:0]   busy = '0;
  logic [NCH-1:0]   gnt = '0;
  logic [NCH-1:0]   pass_o, fail_o, active_o;
  logic [3*NCH-1:0] err_code_o;
  logic [CW-1:0]    pass_cnt_o, fail_cnt_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  req_busy_gnt_monitor #(
    .NUM_CH(NCH), .MIN_BUSY(MINB), .MAX_BUSY(MAXB), .CNT_W(CW)
  ) dut (
    .clk_i(clk), .rst_i(rst), .chk_en_i(chk_en), .cnt_clr_i(cnt_clr),
    .req_i(req), .busy_i(busy), .gnt_i(gnt),
    .pass_o(pass_o), .fail_o(fail_o), .err_code_o(err_code_o), .active_o(active_o),
    .pass_cnt_o(pass_cnt_o), .fail_cnt_o(fail_cnt_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction model: each channel is either free, waiting for its first busy,
  // or counting a busy run; the outcome follows the handshake rules directly.
  int             in_txn [NCH];
  int             got_first [NCH];
  int             nbusy [NCH];
  logic [NCH-1:0] m_pass, m_fail, m_act;
  logic [2:0]     m_err [NCH];
  int             m_pc, m_fc;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        in_txn[c] = 0; got_first[c] = 0; nbusy[c] = 0; m_err[c] = 3'd0;
      end
      m_pass = '0; m_fail = '0; m_pc = 0; m_fc = 0;
    end else begin
      m_pass = '0;
      m_fail = '0;
      for (int c = 0; c < NCH; c++) begin
        if (!in_txn[c]) begin
          if (req[c] && chk_en) begin
            in_txn[c] = 1; got_first[c] = 0; nbusy[c] = 0;
          end
        end else if (!got_first[c]) begin
          if (busy[c]) begin
            got_first[c] = 1; nbusy[c] = 1;
          end else begin
            m_fail[c] = 1'b1; m_err[c] = 3'd1; in_txn[c] = 0;
          end
        end else begin
          in_txn[c] = 0;
          if (gnt[c] && nbusy[c] >= MINB) m_pass[c] = 1'b1;
          else if (busy[c] && nbusy[c] == MAXB) begin m_fail[c] = 1'b1; m_err[c] = 3'd3; end
          else if (busy[c]) begin nbusy[c] = nbusy[c] + 1; in_txn[c] = 1; end
          else if (nbusy[c] < MINB) begin m_fail[c] = 1'b1; m_err[c] = 3'd2; end
          else begin m_fail[c] = 1'b1; m_err[c] = 3'd4; end
        end
      end
      if (cnt_clr) begin
        m_pc = 0; m_fc = 0;
      end else begin
        m_pc = (m_pc + $countones(m_pass) > CMAX) ? CMAX : m_pc + $countones(m_pass);
        m_fc = (m_fc + $countones(m_fail) > CMAX) ? CMAX : m_fc + $countones(m_fail);
      end
    end
  end

  logic [3*NCH-1:0] exp_err;

  always @(negedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      exp_err[3*c +: 3] = m_err[c];
      m_act[c] = (in_txn[c] != 0);
    end
    chk("cmp_pass", 32'(pass_o), 32'(m_pass));
    chk("cmp_fail", 32'(fail_o), 32'(m_fail));
    chk("cmp_err", 32'(err_code_o), 32'(exp_err));
    chk("cmp_active", 32'(active_o), 32'(m_act));
    chk("cmp_pass_cnt", 32'(pass_cnt_o), 32'(m_pc));
    chk("cmp_fail_cnt", 32'(fail_cnt_o), 32'(m_fc));
  end

  task automatic cyc(input logic [3:0] r, input logic [3:0] b, input logic [3:0] g);
    req = r; busy = b; gnt = g;
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    chk("rst_active", 32'(active_o), 32'h0);
    chk("rst_pass_cnt", 32'(pass_cnt_o), 32'h0);
    chk("rst_err", 32'(err_code_o), 32'h0);
    rst = 1'b0;

    // Basic pass on ch0 with two busy cycles.
    cyc(4'h1, 4'h0, 4'h0);
    chk("t1_active", 32'(active_o), 32'h1);
    cyc(4'h0, 4'h1, 4'h0);
    cyc(4'h0, 4'h1, 4'h0);
    cyc(4'h0, 4'h0, 4'h1);
    chk("t1_pass", 32'(pass_o), 32'h1);
    chk("t1_pass_cnt", 32'(pass_cnt_o), 32'd1);

    // Six busy cycles overrun MAX; the late grant is ignored.
    cyc(4'h1, 4'h0, 4'h0);
    repeat (5) cyc(4'h0, 4'h1, 4'h0);
    chk("t2_no_early_fail", 32'(fail_o), 32'h0);
    cyc(4'h0, 4'h1, 4'h0);
    chk("t2_fail", 32'(fail_o), 32'h1);
    chk("t2_err", 32'(err_code_o[2:0]), 32'd3);
    cyc(4'h0, 4'h0, 4'h1);
    chk("t2_late_gnt", 32'(pass_o), 32'h0);
    chk("t2_err_held", 32'(err_code_o[2:0]), 32'd3);

    // NO_BUSY, TOO_SHORT and NO_GNT.
    cyc(4'h2, 4'h0, 4'h0);
    cyc(4'h0, 4'h0, 4'h0);
    chk("t3_no_busy", 32'(err_code_o[5:3]), 32'd1);
    cyc(4'h2, 4'h0, 4'h0);
    cyc(4'h0, 4'h2, 4'h0);
    cyc(4'h0, 4'h0, 4'h2);
    chk("t3_too_short", 32'(err_code_o[5:3]), 32'd2);
    cyc(4'h4, 4'h0, 4'h0);
    cyc(4'h0, 4'h4, 4'h0);
    cyc(4'h0, 4'h4, 4'h0);
    cyc(4'h0, 4'h0, 4'h0);
    chk("t3_no_gnt", 32'(err_code_o[8:6]), 32'd4);
    chk("t3_fail_cnt", 32'(fail_cnt_o), 32'd4);

    // All channels pass together.
    cyc(4'hF, 4'h0, 4'h0);
    cyc(4'h0, 4'hF, 4'h0);
    cyc(4'h0, 4'hF, 4'h0);
    cyc(4'h0, 4'h0, 4'hF);
    chk("t4_pass_all", 32'(pass_o), 32'hF);
    chk("t4_pass_cnt", 32'(pass_cnt_o), 32'd5);

    // chk_en low blocks new requests but not an in-flight one.
    chk_en = 1'b0;
    cyc(4'hF, 4'h0, 4'h0);
    chk("t6_blocked", 32'(active_o), 32'h0);
    chk_en = 1'b1;
    cyc(4'h1, 4'h0, 4'h0);
    chk_en = 1'b0;
    cyc(4'h0, 4'h1, 4'h0);
    cyc(4'h0, 4'h1, 4'h0);
    cyc(4'h0, 4'h0, 4'h1);
    chk("t6_inflight_pass", 32'(pass_o), 32'h1);
    chk_en = 1'b1;

    // Asynchronous reset while ch2 is mid busy run.
    cyc(4'h4, 4'h0, 4'h0);
    repeat (3) cyc(4'h0, 4'h4, 4'h0);
    req = '0; busy = '0; gnt = '0;
    #2 rst = 1'b1;
    #1 chk("t5_active_rst", 32'(active_o), 32'h0);
    chk("t5_cnt_rst", 32'(pass_cnt_o), 32'h0);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("t5_no_verdict", 32'(pass_o | fail_o), 32'h0);
    cyc(4'h4, 4'h0, 4'h0);
    chk("t5_retrack", 32'(active_o), 32'h4);
    cyc(4'h0, 4'h4, 4'h0);
    cyc(4'h0, 4'h4, 4'h0);
    cyc(4'h0, 4'h0, 4'h4);
    chk("t5_pass", 32'(pass_o), 32'h4);

    // Saturation and clear-over-increment.
    cnt_clr = 1'b1;
    cyc(4'h0, 4'h0, 4'h0);
    cnt_clr = 1'b0;
    chk("t4_clr", 32'(pass_cnt_o), 32'd0);
    repeat (4) begin
      cyc(4'hF, 4'h0, 4'h0);
      cyc(4'h0, 4'hF, 4'h0);
      cyc(4'h0, 4'hF, 4'h0);
      cyc(4'h0, 4'h0, 4'hF);
    end
    chk("t4_saturate", 32'(pass_cnt_o), 32'd15);
    cyc(4'hF, 4'h0, 4'h0);
    cyc(4'h0, 4'hF, 4'h0);
    cyc(4'h0, 4'hF, 4'h0);
    cnt_clr = 1'b1;
    cyc(4'h0, 4'h0, 4'hF);
    cnt_clr = 1'b0;
    chk("t4_clr_pass", 32'(pass_o), 32'hF);
    chk("t4_clr_prio", 32'(pass_cnt_o), 32'd0);

    // Random traffic with occasional clears and mid-cycle resets.
    repeat (3000) begin
      if ($urandom_range(0, 399) == 0) begin
        #2 rst = 1'b1;
        #1 chk("rnd_rst_active", 32'(active_o), 32'h0);
        #1 rst = 1'b0;
      end
      chk_en  = ($urandom_range(0, 9) != 0);
      cnt_clr = ($urandom_range(0, 63) == 0);
      for (int c = 0; c < NCH; c++) begin
        req[c]  = ($urandom_range(0, 1) == 1);
        busy[c] = ($urandom_range(0, 9) < 7);
        gnt[c]  = ($urandom_range(0, 9) < 3);
      end
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
